ray_coord_scheduler: RTL

- Parametrised successor to the fixed 640x480 screen-coordinate counter that feeds the ray-march pipeline.
- Generates fixed-point (x, y) screen coordinates for a configurable resolution and step, and issues them round-robin across NUM_LANES ray units.
- Tracks in-flight rays with a credit counter and supports single-frame or continuous mode, with a drain phase before frame completion.
- Sits between the control/register block and the ray units; one clock domain.

---
 rtl/ray_coord_scheduler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ray_coord_scheduler.sv
// ray_coord_scheduler: round-robin fixed-point screen coordinate issuer with credit tracking
module ray_coord_scheduler #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int COORD_W = 32,
  parameter logic [COORD_W-1:0] STEP = 32'h00200000,
  parameter int NUM_LANES = 2,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   continuous,
  input  logic [NUM_LANES-1:0]                   lane_ready,
  input  logic                                   retire,
  output logic                                   issue_valid,
  output logic [NUM_LANES-1:0]                   issue_lane,
  output logic [COORD_W-1:0]                     coord_x,
  output logic [COORD_W-1:0]                     coord_y,
  output logic                                   sof,
  output logic                                   eol,
  output logic                                   frame_done,
  output logic                                   busy,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);
  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam int LW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic cont_q, cont_d, pend_q, pend_d;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [COORD_W-1:0] xa_q, ya_q, cx_q, cy_q;
  logic [LW-1:0] rr_q, sel;
  logic [NUM_LANES-1:0] lane_q;
  logic [OW-1:0] out_q, out_d;
  logic found, fire, last_x, last_y, iv_q, sof_q, eol_q;
  assign last_x = x_q == XW'(H_RES - 1);
  assign last_y = y_q == YW'(V_RES - 1);
  assign fire = state_q == RUN && out_q < OW'(MAX_OUTSTANDING) && found;
  assign frame_done = out_q == '0 && (state_q == DRAIN || (state_q == RUN && pend_q));
  assign busy = state_q != IDLE;
  assign issue_valid = iv_q;
  assign issue_lane = lane_q;
  assign coord_x = cx_q;
  assign coord_y = cy_q;
  assign sof = sof_q;
  assign eol = eol_q;
  assign outstanding = out_q;
  // pick the first ready lane at or after the round-robin pointer
  always_comb begin
    found = 1'b0;
    sel = rr_q;
    for (int i = 0; i < NUM_LANES; i++)
      for (int j = 0; j < NUM_LANES; j++)
        if (!found && lane_ready[j] && (int'(rr_q) + i == j || int'(rr_q) + i == j + NUM_LANES)) begin
          found = 1'b1;
          sel = LW'(j);
        end
  end
  // frame sequencing, continuous-mode latch, wrap-pending flag and credit count
  always_comb begin
    state_d = state_q;
    cont_d = cont_q;
    pend_d = (fire || frame_done) ? 1'b0 : pend_q;
    out_d = out_q + OW'(fire) - OW'(retire && out_q != '0);
    if (state_q == IDLE && start) begin
      state_d = RUN;
      cont_d = continuous;
    end else if (state_q == RUN && fire && last_x && last_y) begin
      state_d = cont_q ? RUN : DRAIN;
      cont_d = cont_q ? continuous : cont_q;
      pend_d = cont_q;
    end else if (state_q == DRAIN && out_q == '0) begin
      state_d = IDLE;
    end
  end
  // control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cont_q <= 1'b0;
      pend_q <= 1'b0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      cont_q <= cont_d;
      pend_q <= pend_d;
      out_q <= out_d;
    end
  end
  // issue registers, pixel indices and accumulated coordinates
  always_ff @(posedge clk) begin
    if (rst) begin
      iv_q <= 1'b0;
      lane_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      sof_q <= 1'b0;
      eol_q <= 1'b0;
      rr_q <= '0;
      x_q <= '0;
      y_q <= '0;
      xa_q <= '0;
      ya_q <= '0;
    end else begin
      iv_q <= fire;
      if (fire) begin
        lane_q <= NUM_LANES'(1) << sel;
        cx_q <= xa_q;
        cy_q <= ya_q;
        sof_q <= x_q == '0 && y_q == '0;
        eol_q <= last_x;
        rr_q <= (int'(sel) == NUM_LANES - 1) ? '0 : sel + 1'b1;
        x_q <= last_x ? '0 : x_q + 1'b1;
        xa_q <= last_x ? '0 : xa_q + STEP;
        if (last_x) begin
          y_q <= last_y ? '0 : y_q + 1'b1;
          ya_q <= last_y ? '0 : ya_q + STEP;
        end
      end
    end
  end
endmodule
